// File: rtl/attn_out_collector.sv
// ============================================================================
// Module   : attn_out_collector
// Brief    : Collects 128 attention-output beats into an SRAM, then serves reads.
//            Optional entry bitmap / duplicate detection: ATTN_COLLECT_BITMAP_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module attn_out_collector #(
    parameter int READ_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [1:0]   in_row,
    input  logic [4:0]   in_group,
    input  logic [127:0] in_data,
    input  logic         in_done,
    output logic         mem_web,
    output logic [6:0]   mem_addr,
    output logic [127:0] mem_din,
    input  logic [127:0] mem_dout,
    input  logic         rd_req,
    input  logic [6:0]   rd_addr,
    output logic         rd_valid,
    output logic [127:0] rd_data,
    output logic         busy,
    output logic         complete,
    output logic [7:0]   count,
    output logic [2:0]   err
);

    localparam logic [7:0] C_ENTRIES = 8'd128;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_count;
    logic [7:0]      w_count_nxt;
    logic [2:0]      r_err;
    logic            r_complete;
    logic [READ_LAT:0] r_rd_pipe;
    logic            w_accept;
    logic            w_rd_fire;
    logic            w_dup;
    logic [6:0]      w_beat_addr;

    assign w_beat_addr = {in_group, in_row};
    // A beat coincident with start belongs to no pass and is silently dropped.
    assign w_accept    = (r_state == S_COLLECT) && in_valid && !start;
    assign w_rd_fire   = (r_state == S_DONE) && rd_req && !start;

`ifdef ATTN_COLLECT_BITMAP_EN
    logic [127:0] r_bitmap;

    assign w_dup = r_bitmap[w_beat_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap <= '0;
        end else if (start) begin
            r_bitmap <= '0;
        end else if (w_accept) begin
            r_bitmap[w_beat_addr] <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_dup && (r_count != C_ENTRIES)) begin
            w_count_nxt = r_count + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if ((w_count_nxt == C_ENTRIES) || in_done) w_state_nxt = S_DRAIN;
                S_DRAIN:   w_state_nxt = S_DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_err      <= '0;
            r_complete <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_count    <= '0;
                r_err      <= '0;
                r_complete <= 1'b0;
            end else begin
                r_count <= w_count_nxt;
                if (w_accept && w_dup) begin
                    r_err[0] <= 1'b1;
                end
                if ((r_state == S_COLLECT) && in_done && (w_count_nxt != C_ENTRIES)) begin
                    r_err[1] <= 1'b1;
                end
                if (in_valid && (r_state != S_COLLECT)) begin
                    r_err[2] <= 1'b1;
                end
                if (r_state == S_DRAIN) begin
                    r_complete <= (r_count == C_ENTRIES);
                end
            end
        end
    end

    // SRAM port: writes and reads share the registered address; web idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_web  <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_web <= 1'b1;
            if (w_accept) begin
                mem_web  <= 1'b0;
                mem_addr <= w_beat_addr;
                mem_din  <= in_data;
            end else if (w_rd_fire) begin
                mem_addr <= rd_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pipe <= '0;
        end else if (start) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= (r_rd_pipe << 1) | (READ_LAT + 1)'(w_rd_fire);
        end
    end

    assign rd_valid = r_rd_pipe[READ_LAT];
    assign rd_data  = rd_valid ? mem_dout : '0;
    assign busy     = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign complete = r_complete;
    assign count    = r_count;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_attn_out_collector.sv
// ============================================================================
// Module   : tb_attn_out_collector
// Brief    : Self-checking bench with SRAM model and write/read scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_attn_out_collector;

    localparam int READ_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   in_row = '0;
    logic [4:0]   in_group = '0;
    logic [127:0] in_data = '0;
    logic         in_done = 1'b0;
    logic         mem_web;
    logic [6:0]   mem_addr;
    logic [127:0] mem_din;
    logic [127:0] mem_dout;
    logic         rd_req = 1'b0;
    logic [6:0]   rd_addr = '0;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         busy;
    logic         complete;
    logic [7:0]   count;
    logic [2:0]   err;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    attn_out_collector #(.READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_row(in_row), .in_group(in_group), .in_data(in_data), .in_done(in_done),
        .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .complete(complete), .count(count), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: address registered inside the macro, data READ_LAT cycles later
    logic [127:0] mem [128];
    logic [6:0]   ap [READ_LAT];
    always @(posedge clk) begin
        if (mem_web == 1'b0) mem[mem_addr] <= mem_din;
        ap[0] <= mem_addr;
        for (int i = 1; i < READ_LAT; i++) ap[i] <= ap[i-1];
    end
    assign mem_dout = mem[ap[READ_LAT-1]];

    typedef struct { logic [6:0] addr; logic [127:0] data; int cyc; } wr_t;
    typedef struct { logic [127:0] data; int cyc; } rd_t;
    typedef struct { logic [6:0] addr; logic [127:0] exp; } rv_t;
    wr_t wq[$];
    rd_t rq[$];
    wr_t mon_w;
    rd_t mon_r;

    function automatic logic [127:0] dat(input int a);
        return {32'hC0DE0000 + 32'(a), ~32'(a), 32'(a) << 4, 32'hDEAD0000 | 32'(a)};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_web === 1'b0) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0d at cycle %0d, none expected", mem_addr, cyc);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", 128'(mem_addr), 128'(mon_w.addr));
                    chk("wr_data", mem_din, mon_w.data);
                    chk("wr_cycle", 128'(cyc), 128'(mon_w.cyc));
                end
            end
            if (rd_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_valid: cycle %0d, none expected", cyc);
                end else begin
                    mon_r = rq.pop_front();
                    chk("rd_data", rd_data, mon_r.data);
                    chk("rd_cycle", 128'(cyc), 128'(mon_r.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input bit expect_wr);
        in_valid = 1'b1;
        in_group = a[6:2];
        in_row   = a[1:0];
        in_data  = dat(a);
        if (expect_wr) wq.push_back('{a[6:0], dat(a), cyc + 1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        chk("reach_done", 128'(busy), 128'(0));
    endtask

    rv_t rtab[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rtab[0] = '{7'd5,   dat(5)};
        rtab[1] = '{7'd6,   dat(6)};
        rtab[2] = '{7'd7,   dat(7)};
        rtab[3] = '{7'd0,   dat(0)};
        rtab[4] = '{7'd127, dat(127)};
        rtab[5] = '{7'd64,  dat(64)};

        // Reset values
        repeat (3) tick();
        chk("rst_web", 128'(mem_web), 128'(1));
        chk("rst_addr", 128'(mem_addr), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_complete", 128'(complete), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        rst_n = 1'b1;
        tick();

        // Beat in IDLE: dropped and flagged; start clears the flag
        beat(20, 1'b0);
        chk("idle_beat_err", 128'(err), 128'(3'b100));
        pulse_start();
        chk("start_clr_err", 128'(err), 128'(0));
        chk("collect_busy", 128'(busy), 128'(1));

        // Full pass in address order
        for (int a = 0; a < 128; a++) beat(a, 1'b1);
        chk("full_count", 128'(count), 128'(128));
        wait_done();
        chk("full_complete", 128'(complete), 128'(1));
        chk("full_count_done", 128'(count), 128'(128));
        chk("full_err", 128'(err), 128'(0));

        // Back-to-back readback from the vector table
        for (int i = 0; i < 6; i++) begin
            rd_req  = 1'b1;
            rd_addr = rtab[i].addr;
            rq.push_back('{rtab[i].exp, cyc + READ_LAT + 1});
            tick();
        end
        rd_req = 1'b0;
        repeat (READ_LAT + 3) tick();
        chk("rd_drained", 128'(rq.size()), 128'(0));

        // Beat in DONE: dropped and flagged
        beat(10, 1'b0);
        chk("done_beat_err", 128'(err), 128'(3'b100));
        chk("done_complete_hold", 128'(complete), 128'(1));

        // Read in flight when start arrives is discarded; beat with start dropped silently
        rd_req = 1'b1; rd_addr = 7'd9;
        tick();
        rd_req = 1'b0;
        in_valid = 1'b1; in_group = 5'd0; in_row = 2'd0; in_data = dat(0);
        pulse_start();
        in_valid = 1'b0;
        chk("restart_err", 128'(err), 128'(0));
        chk("restart_count", 128'(count), 128'(0));
        chk("restart_complete", 128'(complete), 128'(0));

        // Duplicate beat plus early in_done; rd_req during COLLECT ignored
        beat(13, 1'b1);
        beat(13, 1'b1);
        rd_req = 1'b1; rd_addr = 7'd3;
        for (int a = 0, n = 0; n < 99; a++) begin
            if (a != 13) begin
                beat(a, 1'b1);
                n++;
            end
        end
        rd_req = 1'b0;
`ifdef ATTN_COLLECT_BITMAP_EN
        chk("dup_count", 128'(count), 128'(100));
`else
        chk("dup_count", 128'(count), 128'(101));
`endif
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        wait_done();
        chk("early_complete", 128'(complete), 128'(0));
`ifdef ATTN_COLLECT_BITMAP_EN
        chk("early_err", 128'(err), 128'(3'b011));
        chk("early_count", 128'(count), 128'(100));
`else
        chk("early_err", 128'(err), 128'(3'b010));
        chk("early_count", 128'(count), 128'(101));
`endif

        // Reset mid-pass after 40 beats
        pulse_start();
        for (int a = 0; a < 40; a++) beat(a, 1'b1);
        tick();
        in_valid = 1'b1; in_group = 5'd12; in_row = 2'd2; in_data = dat(50);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_web", 128'(mem_web), 128'(1));
        chk("midrst_addr", 128'(mem_addr), 128'(0));
        chk("midrst_din", mem_din, 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_count", 128'(count), 128'(0));
        chk("midrst_err", 128'(err), 128'(0));
        chk("midrst_rd_data", rd_data, 128'(0));
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        pulse_start();
        for (int a = 127; a >= 0; a--) beat(a, 1'b1);
        wait_done();
        chk("post_rst_complete", 128'(complete), 128'(1));
        chk("post_rst_count", 128'(count), 128'(128));
        chk("post_rst_err", 128'(err), 128'(0));

        tick();
        chk("wq_empty", 128'(wq.size()), 128'(0));
        chk("rq_empty", 128'(rq.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
